// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO: width functions, read-mode constants
// and the parameter legality check used at elaboration.
package fifo_pkg;

    localparam int unsigned FWFT_STD = 0;
    localparam int unsigned FWFT_ON  = 1;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    // True when depth, thresholds and read mode form a legal configuration.
    function automatic bit params_ok(input int unsigned depth,
                                     input int unsigned afull,
                                     input int unsigned aempty,
                                     input int unsigned fwft);
        return is_pow2(depth) && (depth >= 2) &&
               (afull >= 1) && (afull <= depth) &&
               (aempty <= depth - 1) &&
               ((fwft == FWFT_STD) || (fwft == FWFT_ON));
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, combinational read.
module fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is intentionally not reset; only control state is.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read,
// threshold flags, fill count and registered overflow/underflow pulses.
module sync_fifo_param #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned FWFT          = 0,
    parameter int unsigned AFULL_THRESH  = DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       rvalid_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    import fifo_pkg::*;

    localparam int unsigned AW = ptr_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    if (!params_ok(DEPTH, AFULL_THRESH, AEMPTY_THRESH, FWFT)) begin : g_param_check
        $error("sync_fifo_param: illegal DEPTH, threshold or FWFT parameter");
    end

    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_nxt;
    logic             full_q;
    logic             empty_q;
    logic             afull_q;
    logic             aempty_q;
    logic             ovf_q;
    logic             unf_q;
    logic             rd_accept;
    logic             wr_accept;
    logic [WIDTH-1:0] mem_rdata;

    // A full FIFO still takes a write when a read frees the slot on the same edge.
    always_comb begin
        rd_accept = rd_en_i & ~empty_q;
        wr_accept = wr_en_i & (~full_q | rd_accept);
        count_nxt = count_q;
        if (wr_accept && !rd_accept) begin
            count_nxt = count_q + CW'(1);
        end else if (rd_accept && !wr_accept) begin
            count_nxt = count_q - CW'(1);
        end
    end

    // Pointers wrap naturally; flags follow the next-state count.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_accept) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q  <= count_nxt;
            full_q   <= (count_nxt == DEPTH_C);
            empty_q  <= (count_nxt == '0);
            afull_q  <= (count_nxt >= AFULL_C);
            aempty_q <= (count_nxt <= AEMPTY_C);
            ovf_q    <= wr_en_i & ~wr_accept;
            unf_q    <= rd_en_i & ~rd_accept;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_accept),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    if (FWFT == FWFT_ON) begin : g_fwft
        assign rdata_o  = mem_rdata;
        assign rvalid_o = ~empty_q;
    end else begin : g_std
        logic [WIDTH-1:0] rdata_q;
        logic             rvalid_q;

        // Captures the head word on an accepted pop; holds otherwise.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_accept;
                if (rd_accept) begin
                    rdata_q <= mem_rdata;
                end
            end
        end

        assign rdata_o  = rdata_q;
        assign rvalid_o = rvalid_q;
    end

    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = afull_q;
    assign almost_empty_o = aempty_q;
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: standard-mode and FWFT instances, DEPTH=8.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_wr = 1'b0;
    logic       s_rd = 1'b0;
    logic [7:0] s_wdata = 8'h00;
    logic       f_wr = 1'b0;
    logic       f_rd = 1'b0;

    logic [7:0] s_rdata;
    logic       s_rvalid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [3:0] s_count;
    logic [7:0] f_rdata;
    logic       f_rvalid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [3:0] f_count;

    int checks = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    logic       exp_unf = 1'b0;
    logic       exp_rv = 1'b0;
    logic [7:0] mon_exp;

    always #5 clk = ~clk;

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .FWFT(0)) u_std (
        .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(s_wr), .wdata_i(s_wdata), .rd_en_i(s_rd),
        .rdata_o(s_rdata), .rvalid_o(s_rvalid), .full_o(s_full), .empty_o(s_empty),
        .almost_full_o(s_af), .almost_empty_o(s_ae), .count_o(s_count),
        .overflow_o(s_ovf), .underflow_o(s_unf)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .FWFT(1)) u_fwft (
        .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(f_wr), .wdata_i(s_wdata), .rd_en_i(f_rd),
        .rdata_o(f_rdata), .rvalid_o(f_rvalid), .full_o(f_full), .empty_o(f_empty),
        .almost_full_o(f_af), .almost_empty_o(f_ae), .count_o(f_count),
        .overflow_o(f_ovf), .underflow_o(f_unf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid pulse from the standard instance consumes one expected word.
    always @(negedge clk) begin
        if (rst_n && s_rvalid) begin
            if (exp_q.size() == 0) begin
                chk("rvalid_unexpected", 32'(s_rvalid), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rdata", 32'(s_rdata), 32'(mon_exp));
            end
        end
    end

    task automatic check_state();
        int n;
        n = mq.size();
        chk("count", 32'(s_count), 32'(n));
        chk("full", 32'(s_full), 32'(n == 8));
        chk("empty", 32'(s_empty), 32'(n == 0));
        chk("almost_full", 32'(s_af), 32'(n >= 6));
        chk("almost_empty", 32'(s_ae), 32'(n <= 2));
        chk("overflow", 32'(s_ovf), 32'(exp_ovf));
        chk("underflow", 32'(s_unf), 32'(exp_unf));
        chk("rvalid", 32'(s_rvalid), 32'(exp_rv));
    endtask

    // One clock of stimulus on the standard instance; the reference queue decides acceptance.
    task automatic cyc(input logic wr, input logic [7:0] wd, input logic rd);
        int  n;
        logic ra, wa;
        n  = mq.size();
        ra = rd && (n > 0);
        wa = wr && ((n < 8) || ra);
        if (ra) exp_q.push_back(mq.pop_front());
        if (wa) mq.push_back(wd);
        exp_ovf = wr && !wa;
        exp_unf = rd && !ra;
        exp_rv  = ra;
        s_wr = wr; s_wdata = wd; s_rd = rd;
        @(posedge clk); #1;
        s_wr = 1'b0; s_rd = 1'b0;
        check_state();
    endtask

    task automatic fstep(input logic wr, input logic [7:0] wd, input logic rd);
        f_wr = wr; s_wdata = wd; f_rd = rd;
        @(posedge clk); #1;
        f_wr = 1'b0; f_rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_state();
        chk("reset_rdata", 32'(s_rdata), 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Fill 0x01..0x08, then one overflow attempt.
        for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i), 1'b0);
        chk("full_after_8", 32'(s_full), 32'd1);
        chk("count_after_8", 32'(s_count), 32'd8);
        cyc(1'b1, 8'hAA, 1'b0);
        chk("overflow_pulse", 32'(s_ovf), 32'd1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("overflow_cleared", 32'(s_ovf), 32'd0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("empty_after_drain", 32'(s_empty), 32'd1);

        // Underflow alone, then write+read into empty, then read back 0x55.
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h55, 1'b1);
        chk("underflow_back_to_back", 32'(s_unf), 32'd1);
        chk("count_after_55", 32'(s_count), 32'd1);
        cyc(1'b0, 8'h00, 1'b1);

        // Pass-through on a full FIFO: 0x99 must come out last.
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
        cyc(1'b1, 8'h99, 1'b1);
        chk("passthru_full", 32'(s_full), 32'd1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);

        // Asynchronous reset mid-burst at count 5.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
        chk("count_before_reset", 32'(s_count), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        mq.delete(); exp_q.delete();
        exp_ovf = 1'b0; exp_unf = 1'b0; exp_rv = 1'b0;
        check_state();
        chk("async_reset_rdata", 32'(s_rdata), 32'h0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Random traffic biased towards writes so both pointers wrap.
        for (int i = 0; i < 40; i++)
            cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
        while (mq.size() > 0) cyc(1'b0, 8'h00, 1'b1);
        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // First-word-fall-through instance.
        fstep(1'b1, 8'h3C, 1'b0);
        chk("fwft_head", 32'(f_rdata), 32'h3C);
        chk("fwft_rvalid", 32'(f_rvalid), 32'd1);
        chk("fwft_count1", 32'(f_count), 32'd1);
        chk("fwft_ae", 32'(f_ae), 32'd1);
        fstep(1'b0, 8'h00, 1'b1);
        chk("fwft_empty", 32'(f_empty), 32'd1);
        chk("fwft_rvalid_low", 32'(f_rvalid), 32'd0);
        fstep(1'b1, 8'hA1, 1'b0);
        fstep(1'b1, 8'hB2, 1'b0);
        chk("fwft_head_a1", 32'(f_rdata), 32'hA1);
        chk("fwft_count2", 32'(f_count), 32'd2);
        fstep(1'b0, 8'h00, 1'b1);
        chk("fwft_head_b2", 32'(f_rdata), 32'hB2);
        fstep(1'b0, 8'h00, 1'b1);
        fstep(1'b0, 8'h00, 1'b1);
        chk("fwft_underflow", 32'(f_unf), 32'd1);
        chk("fwft_overflow", 32'(f_ovf), 32'd0);
        chk("fwft_full", 32'(f_full), 32'd0);
        chk("fwft_af", 32'(f_af), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
